// File: rtl/dcache_rd_arbiter.sv
// dcache_rd_arbiter
//   Shares the single dCache read port between demand loads and the prefetch
//   engine. Prefetch addresses wait in a small FIFO. Demand wins unless it has
//   held the port for STARVE_MAX grants while prefetches are waiting. Every
//   issued read is tracked through an RD_LAT-deep pipeline so that the
//   returning data is routed to the requester that issued it.
//   Optional build macro PF_DEDUP_EN: silently discard a prefetch push whose
//   address is already queued or already in flight.
module dcache_rd_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int PF_DEPTH   = 4,
  parameter int STARVE_MAX = 3,
  parameter int RD_LAT     = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          dmd_req,
  input  logic [AW-1:0] dmd_addr,
  output logic          dmd_gnt,
  output logic          dmd_rvalid,
  output logic [DW-1:0] dmd_rdata,
  input  logic          pf_push,
  input  logic [AW-1:0] pf_addr,
  output logic          pf_full,
  input  logic          pf_flush,
  output logic          pf_rvalid,
  output logic [AW-1:0] pf_raddr,
  output logic [DW-1:0] pf_rdata,
  output logic [7:0]    pf_drop_cnt,
  output logic [AW-1:0] cache_rd_addr,
  input  logic [DW-1:0] cache_rd_data
);

  localparam int PTR_W = $clog2(PF_DEPTH);
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [STV_W-1:0] STV_MAX   = STV_W'(STARVE_MAX);
  localparam logic [PTR_W:0]   FULL_DIFF = {1'b1, {PTR_W{1'b0}}};

  // Prefetch FIFO: storage plus wrap-bit pointers.
  logic [AW-1:0]    fifo_mem_q [PF_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             pf_full_q, pf_full_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  // Arbitration state.
  logic [STV_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [AW-1:0]    last_addr_q, last_addr_d;

  // Response tracking pipeline, stage 0 is loaded at grant.
  logic             pipe_vld_q  [RD_LAT];
  logic             pipe_vld_d  [RD_LAT];
  logic             pipe_pf_q   [RD_LAT];
  logic             pipe_pf_d   [RD_LAT];
  logic [AW-1:0]    pipe_addr_q [RD_LAT];
  logic [AW-1:0]    pipe_addr_d [RD_LAT];

  // Registered response outputs.
  logic             dmd_rvalid_q, dmd_rvalid_d;
  logic [DW-1:0]    dmd_rdata_q, dmd_rdata_d;
  logic             pf_rvalid_q, pf_rvalid_d;
  logic [AW-1:0]    pf_raddr_q, pf_raddr_d;
  logic [DW-1:0]    pf_rdata_q, pf_rdata_d;

  logic             fifo_empty, fifo_full;
  logic [AW-1:0]    fifo_head;
  logic             sel_dmd, sel_pf;
  logic             push_en, drop_en, dup_hit;
  logic             tail_vld, tail_pf;

  // Arbitration: demand first unless the starvation guard forces a prefetch.
  // NOTE: every signal written in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    fifo_empty    = (wr_ptr_q == rd_ptr_q);
    fifo_full     = ((wr_ptr_q ^ rd_ptr_q) == FULL_DIFF);
    fifo_head     = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
    sel_dmd       = dmd_req && (fifo_empty || (starve_cnt_q < STV_MAX));
    sel_pf        = !sel_dmd && !fifo_empty && !pf_flush;
    cache_rd_addr = last_addr_q;
    if (sel_dmd) begin
      cache_rd_addr = dmd_addr;
    end else if (sel_pf) begin
      cache_rd_addr = fifo_head;
    end
  end

  assign dmd_gnt = sel_dmd;

`ifdef PF_DEDUP_EN
  logic [PTR_W:0]   fifo_count;
  logic [PTR_W-1:0] slot_off [PF_DEPTH];

  // Duplicate detection against queued entries and in-flight prefetches,
  // using the state before this cycle's pop.
  always_comb begin
    fifo_count = wr_ptr_q - rd_ptr_q;
    dup_hit    = 1'b0;
    for (int i = 0; i < PF_DEPTH; i++) begin
      slot_off[i] = PTR_W'(i) - rd_ptr_q[PTR_W-1:0];
      if (({1'b0, slot_off[i]} < fifo_count) && (fifo_mem_q[i] == pf_addr)) begin
        dup_hit = 1'b1;
      end
    end
    for (int i = 0; i < RD_LAT; i++) begin
      if (pipe_vld_q[i] && pipe_pf_q[i] && (pipe_addr_q[i] == pf_addr)) begin
        dup_hit = 1'b1;
      end
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

  // FIFO pointer, full flag, drop counter and starvation counter updates.
  always_comb begin
    push_en  = pf_push && !pf_flush && !dup_hit && (!fifo_full || sel_pf);
    drop_en  = pf_push && !pf_flush && !dup_hit && fifo_full && !sel_pf;
    wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push_en};
    rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, sel_pf};
    if (pf_flush) begin
      rd_ptr_d = wr_ptr_q;
    end
    pf_full_d  = ((wr_ptr_d ^ rd_ptr_d) == FULL_DIFF);
    drop_cnt_d = drop_cnt_q;
    if (drop_en && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
    starve_cnt_d = starve_cnt_q;
    if (pf_flush || fifo_empty || sel_pf) begin
      starve_cnt_d = '0;
    end else if (sel_dmd && (starve_cnt_q < STV_MAX)) begin
      starve_cnt_d = starve_cnt_q + STV_W'(1);
    end
    last_addr_d = cache_rd_addr;
  end

  // Response pipeline shift; a flush kills every in-flight prefetch.
  always_comb begin
    pipe_vld_d[0]  = sel_dmd || sel_pf;
    pipe_pf_d[0]   = sel_pf;
    pipe_addr_d[0] = cache_rd_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1] && !(pf_flush && pipe_pf_q[i-1]);
      pipe_pf_d[i]   = pipe_pf_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end
  end

  // Pipeline tail: capture returning data into the owning requester's outputs.
  always_comb begin
    tail_pf      = pipe_pf_q[RD_LAT-1];
    tail_vld     = pipe_vld_q[RD_LAT-1] && !(pf_flush && tail_pf);
    dmd_rvalid_d = tail_vld && !tail_pf;
    pf_rvalid_d  = tail_vld && tail_pf;
    dmd_rdata_d  = dmd_rdata_q;
    pf_rdata_d   = pf_rdata_q;
    pf_raddr_d   = pf_raddr_q;
    if (dmd_rvalid_d) begin
      dmd_rdata_d = cache_rd_data;
    end
    if (pf_rvalid_d) begin
      pf_rdata_d = cache_rd_data;
      pf_raddr_d = pipe_addr_q[RD_LAT-1];
    end
  end

  // Control and datapath registers with asynchronous reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pf_full_q    <= 1'b0;
      drop_cnt_q   <= '0;
      starve_cnt_q <= '0;
      last_addr_q  <= '0;
      dmd_rvalid_q <= 1'b0;
      dmd_rdata_q  <= '0;
      pf_rvalid_q  <= 1'b0;
      pf_raddr_q   <= '0;
      pf_rdata_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld_q[i]  <= 1'b0;
        pipe_pf_q[i]   <= 1'b0;
        pipe_addr_q[i] <= '0;
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pf_full_q    <= pf_full_d;
      drop_cnt_q   <= drop_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      last_addr_q  <= last_addr_d;
      dmd_rvalid_q <= dmd_rvalid_d;
      dmd_rdata_q  <= dmd_rdata_d;
      pf_rvalid_q  <= pf_rvalid_d;
      pf_raddr_q   <= pf_raddr_d;
      pf_rdata_q   <= pf_rdata_d;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_d[i];
        pipe_pf_q[i]   <= pipe_pf_d[i];
        pipe_addr_q[i] <= pipe_addr_d[i];
      end
    end
  end

  // FIFO storage write.
  // NOTE: the storage array has no reset; the pointers define which entries
  // are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_en) begin
      fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= pf_addr;
    end
  end

  assign pf_full     = pf_full_q;
  assign pf_drop_cnt = drop_cnt_q;
  assign dmd_rvalid  = dmd_rvalid_q;
  assign dmd_rdata   = dmd_rdata_q;
  assign pf_rvalid   = pf_rvalid_q;
  assign pf_raddr    = pf_raddr_q;
  assign pf_rdata    = pf_rdata_q;

endmodule

// File: tb/tb_dcache_rd_arbiter.sv
// Testbench for dcache_rd_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based model. Build with PF_DEDUP_EN
// defined to exercise the duplicate-discard variant.
module tb_dcache_rd_arbiter;

  localparam int AW         = 8;
  localparam int DW         = 32;
  localparam int PF_DEPTH   = 4;
  localparam int STARVE_MAX = 3;
  localparam int RD_LAT     = 1;

  logic          clk;
  logic          reset_n;
  logic          dmd_req;
  logic [AW-1:0] dmd_addr;
  logic          dmd_gnt;
  logic          dmd_rvalid;
  logic [DW-1:0] dmd_rdata;
  logic          pf_push;
  logic [AW-1:0] pf_addr;
  logic          pf_full;
  logic          pf_flush;
  logic          pf_rvalid;
  logic [AW-1:0] pf_raddr;
  logic [DW-1:0] pf_rdata;
  logic [7:0]    pf_drop_cnt;
  logic [AW-1:0] cache_rd_addr;
  logic [DW-1:0] cache_rd_data;

  dcache_rd_arbiter #(
    .AW(AW), .DW(DW), .PF_DEPTH(PF_DEPTH), .STARVE_MAX(STARVE_MAX), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .dmd_req(dmd_req), .dmd_addr(dmd_addr), .dmd_gnt(dmd_gnt),
    .dmd_rvalid(dmd_rvalid), .dmd_rdata(dmd_rdata),
    .pf_push(pf_push), .pf_addr(pf_addr), .pf_full(pf_full), .pf_flush(pf_flush),
    .pf_rvalid(pf_rvalid), .pf_raddr(pf_raddr), .pf_rdata(pf_rdata),
    .pf_drop_cnt(pf_drop_cnt),
    .cache_rd_addr(cache_rd_addr), .cache_rd_data(cache_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache RAM stand-in: every location holds its address plus 0x100.
  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return DW'(a) + DW'(32'h100);
  endfunction

  logic [DW-1:0] ram_pipe [RD_LAT];
  always @(posedge clk) begin
    ram_pipe[0] <= ram_word(cache_rd_addr);
    for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign cache_rd_data = ram_pipe[RD_LAT-1];

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    bit            is_pf;
    logic [AW-1:0] addr;
  } resp_t;

  int            cyc;
  int            n_cmp;
  int            n_mis;
  logic [AW-1:0] m_fifo [$];
  resp_t         m_resp [$];
  int            m_starve;
  int            m_drop;
  logic [AW-1:0] m_last;
  bit            e_dmd_rv, e_pf_rv;
  logic [DW-1:0] e_dmd_rd, e_pf_rd;
  logic [AW-1:0] e_pf_ra;
  bit            g_dmd, g_pf;
  int            obs_pf_rv, obs_dmd_rv, obs_dmd_gnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_resp.delete();
    m_starve = 0;
    m_drop   = 0;
    m_last   = '0;
    e_dmd_rv = 0;
    e_pf_rv  = 0;
    e_dmd_rd = '0;
    e_pf_rd  = '0;
    e_pf_ra  = '0;
    g_dmd    = 0;
    g_pf     = 0;
  endtask

  task automatic clear_obs();
    obs_pf_rv   = 0;
    obs_dmd_rv  = 0;
    obs_dmd_gnt = 0;
  endtask

  task automatic idle_inputs();
    dmd_req  = 1'b0;
    dmd_addr = '0;
    pf_push  = 1'b0;
    pf_addr  = '0;
    pf_flush = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_dmd_rvalid"}, 32'(dmd_rvalid), 32'd0);
    check({tag, "_pf_rvalid"},  32'(pf_rvalid),  32'd0);
    check({tag, "_pf_full"},    32'(pf_full),    32'd0);
    check({tag, "_drop_cnt"},   32'(pf_drop_cnt), 32'd0);
    check({tag, "_dmd_rdata"},  dmd_rdata, 32'd0);
    check({tag, "_pf_rdata"},   pf_rdata,  32'd0);
    check({tag, "_pf_raddr"},   32'(pf_raddr), 32'd0);
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input bit req, input logic [AW-1:0] da, input bit push,
                      input logic [AW-1:0] pa, input bit flush);
    resp_t         r;
    resp_t         keep [$];
    bit            empty;
    bit            dup;
    logic [AW-1:0] addr;
    @(negedge clk);
    dmd_req  = req;
    dmd_addr = da;
    pf_push  = push;
    pf_addr  = pa;
    pf_flush = flush;
    #1;
    e_dmd_rv = 0;
    e_pf_rv  = 0;
    if (m_resp.size() > 0 && m_resp[0].due == cyc) begin
      r = m_resp.pop_front();
      if (r.is_pf) begin
        e_pf_rv = 1;
        e_pf_ra = r.addr;
        e_pf_rd = ram_word(r.addr);
      end else begin
        e_dmd_rv = 1;
        e_dmd_rd = ram_word(r.addr);
      end
    end
    empty = (m_fifo.size() == 0);
    g_dmd = req && (empty || m_starve < STARVE_MAX);
    g_pf  = !g_dmd && !empty && !flush;
    addr  = g_dmd ? da : (g_pf ? m_fifo[0] : m_last);

    check("dmd_gnt",       32'(dmd_gnt),       32'(g_dmd));
    check("cache_rd_addr", 32'(cache_rd_addr), 32'(addr));
    check("pf_full",       32'(pf_full),       32'(m_fifo.size() == PF_DEPTH));
    check("pf_drop_cnt",   32'(pf_drop_cnt),   32'(m_drop));
    check("dmd_rvalid",    32'(dmd_rvalid),    32'(e_dmd_rv));
    check("dmd_rdata",     dmd_rdata,          e_dmd_rd);
    check("pf_rvalid",     32'(pf_rvalid),     32'(e_pf_rv));
    check("pf_raddr",      32'(pf_raddr),      32'(e_pf_ra));
    check("pf_rdata",      pf_rdata,           e_pf_rd);
    obs_pf_rv   += int'(pf_rvalid);
    obs_dmd_rv  += int'(dmd_rvalid);
    obs_dmd_gnt += int'(dmd_gnt);

    dup = 0;
`ifdef PF_DEDUP_EN
    foreach (m_fifo[i]) if (m_fifo[i] == pa) dup = 1;
    foreach (m_resp[i]) if (m_resp[i].is_pf && m_resp[i].addr == pa) dup = 1;
`endif
    if (flush || empty || g_pf) m_starve = 0;
    else if (g_dmd && m_starve < STARVE_MAX) m_starve++;
    if (flush) begin
      m_fifo.delete();
      foreach (m_resp[i]) if (!m_resp[i].is_pf) keep.push_back(m_resp[i]);
      m_resp = keep;
    end else begin
      if (g_pf) void'(m_fifo.pop_front());
      if (push && !dup) begin
        if (m_fifo.size() < PF_DEPTH) m_fifo.push_back(pa);
        else if (m_drop < 255) m_drop++;
      end
    end
    if (g_dmd || g_pf) begin
      m_resp.push_back('{cyc + RD_LAT + 1, g_pf, addr});
      m_last = addr;
    end
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    clear_obs();
    #1;
    check_zero_outputs("rst");
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic mid_reset();
    #2;
    reset_n = 1'b0;
    idle_inputs();
    #1;
    check_zero_outputs("async_rst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    clear_obs();
  endtask

  bit            rq;
  logic [AW-1:0] ra;
  logic [5:0]    gnt_hist;
  int            req_pct, push_pct;

  initial begin
    cyc = 0; n_cmp = 0; n_mis = 0;
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    clear_obs();

    // Prefetch-only traffic returns in order, data = addr + 0x100.
    do_reset();
    step(0, '0, 1, 8'h10, 0);
    step(0, '0, 1, 8'h11, 0);
    check("t1_issue_10", 32'(cache_rd_addr), 32'h10);
    step(0, '0, 0, '0, 0);
    check("t1_issue_11", 32'(cache_rd_addr), 32'h11);
    step(0, '0, 0, '0, 0);
    check("t1_rv0", 32'(pf_rvalid), 32'd1);
    check("t1_ra0", 32'(pf_raddr), 32'h10);
    check("t1_rd0", pf_rdata, 32'h110);
    step(0, '0, 0, '0, 0);
    check("t1_ra1", 32'(pf_raddr), 32'h11);
    check("t1_rd1", pf_rdata, 32'h111);
    idle_steps(2);
    check("t1_pf_count", 32'(obs_pf_rv), 32'd2);

    // Starvation guard: three demand grants, one forced prefetch, demand again.
    do_reset();
    step(0, '0, 1, 8'h20, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, AW'(8'h80 + i), 0, '0, 0);
      gnt_hist[i] = dmd_gnt;
      if (i == 3) check("t2_forced_pf", 32'(cache_rd_addr), 32'h20);
    end
    idle_steps(4);
    check("t2_gnt_pattern", 32'(gnt_hist), 32'b110111);
    check("t2_gnt_count", 32'(obs_dmd_gnt), 32'd5);
    check("t2_rv_count", 32'(obs_dmd_rv), 32'd5);

    // FIFO overflow while demand holds the port.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1, AW'(8'h90 + i), 1, AW'(8'hA0 + i), 0);
      if (i == 3) check("t3_not_full_yet", 32'(pf_full), 32'd0);
      if (i == 4) begin
        check("t3_full", 32'(pf_full), 32'd1);
        check("t3_forced_pf", 32'(cache_rd_addr), 32'hA0);
      end
    end
    step(0, '0, 0, '0, 0);
    check("t3_drop_cnt", 32'(pf_drop_cnt), 32'd2);
    idle_steps(8);
    check("t3_pf_count", 32'(obs_pf_rv), 32'd5);

    // Flush kills queued and in-flight prefetches; demand continues.
    do_reset();
    step(1, 8'h50, 1, 8'h30, 0);
    step(1, 8'h51, 1, 8'h31, 0);
    step(1, 8'h52, 1, 8'h32, 0);
    step(0, '0, 0, '0, 0);
    check("t4_issue_30", 32'(cache_rd_addr), 32'h30);
    step(0, '0, 1, 8'h33, 1);
    step(1, 8'h55, 0, '0, 0);
    check("t4_dmd_gnt", 32'(dmd_gnt), 32'd1);
    step(0, '0, 0, '0, 0);
    step(0, '0, 0, '0, 0);
    check("t4_dmd_rv", 32'(dmd_rvalid), 32'd1);
    check("t4_dmd_rd", dmd_rdata, 32'h155);
    idle_steps(3);
    check("t4_no_pf_rv", 32'(obs_pf_rv), 32'd0);
    check("t4_dmd_count", 32'(obs_dmd_rv), 32'd4);
    check("t4_drop", 32'(pf_drop_cnt), 32'd0);

    // Duplicate pushes of 0x40: queued twice, then again while in flight.
    do_reset();
    step(1, 8'h01, 1, 8'h40, 0);
    step(1, 8'h02, 1, 8'h40, 0);
    step(0, '0, 0, '0, 0);
    step(0, '0, 1, 8'h40, 0);
    idle_steps(6);
`ifdef PF_DEDUP_EN
    check("t6_reads_of_40", 32'(obs_pf_rv), 32'd1);
`else
    check("t6_reads_of_40", 32'(obs_pf_rv), 32'd3);
`endif
    check("t6_drop", 32'(pf_drop_cnt), 32'd0);

    // Randomized traffic with periodic mid-cycle resets.
    do_reset();
    rq = 0;
    ra = '0;
    for (int n = 0; n < 2000; n++) begin
      req_pct  = ((n / 200) % 2 == 0) ? 80 : 35;
      push_pct = ((n / 300) % 2 == 0) ? 85 : 40;
      if (!(rq && !g_dmd)) begin
        rq = ($urandom_range(0, 99) < req_pct);
        ra = AW'($urandom);
      end
      step(rq, ra, ($urandom_range(0, 99) < push_pct), AW'($urandom_range(0, 15)),
           ($urandom_range(0, 99) < 4));
      if (n % 500 == 250) begin
        mid_reset();
        rq = 0;
      end
    end
    idle_steps(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
